datamem_arbiter: RTL and testbench

//   Shares the single-port CPU data memory between two requesters:

---
 rtl/datamem_arbiter.sv | 95 +++++++++
 tb/tb_datamem_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/datamem_arbiter.sv
// Two-port arbiter in front of the single-port CPU data memory.
// Port A has fixed priority; a starvation counter periodically forces a grant to port B.
module datamem_arbiter #(
    parameter int unsigned ADDR_BITS = 7,
    parameter int unsigned MAX_WAIT  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_data,
    output logic        a_gnt,
    output logic        a_valid,
    output logic [31:0] a_q,
    output logic        a_err,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_data,
    output logic        b_gnt,
    output logic        b_valid,
    output logic [31:0] b_q,
    output logic        b_err,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_data,
    input  logic [31:0] mem_q,
    output logic [1:0]  owner
);

    // MAX_WAIT=0 would give a zero-width counter; keep one bit, it simply stays 0.
    localparam int unsigned CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    logic [CW-1:0] wait_cnt;
    logic          starve;
    logic          a_oor;
    logic          b_oor;

    assign a_oor  = |a_addr[31:ADDR_BITS];
    assign b_oor  = |b_addr[31:ADDR_BITS];
    assign starve = b_req && (wait_cnt == CW'(MAX_WAIT));

    always_comb begin
        a_gnt    = 1'b0;
        b_gnt    = 1'b0;
        mem_addr = '0;
        mem_we   = 1'b0;
        mem_data = '0;
        if (!reset) begin
            a_gnt = a_req && !starve;
            b_gnt = b_req && !a_gnt;
        end
        if (a_gnt) begin
            mem_addr = a_addr;
            mem_we   = a_we && !a_oor;
            mem_data = a_data;
        end else if (b_gnt) begin
            mem_addr = b_addr;
            mem_we   = b_we && !b_oor;
            mem_data = b_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_valid  <= 1'b0;
            a_q      <= '0;
            a_err    <= 1'b0;
            b_valid  <= 1'b0;
            b_q      <= '0;
            b_err    <= 1'b0;
            wait_cnt <= '0;
            owner    <= '0;
        end else begin
            a_valid <= a_gnt;
            b_valid <= b_gnt;
            owner   <= {b_gnt, a_gnt};
            if (a_gnt) begin
                a_q   <= a_oor ? '0 : mem_q;
                a_err <= a_oor;
            end
            if (b_gnt) begin
                b_q   <= b_oor ? '0 : mem_q;
                b_err <= b_oor;
            end
            if (b_gnt || !b_req) begin
                wait_cnt <= '0;
            end else if (a_gnt && (wait_cnt != CW'(MAX_WAIT))) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_datamem_arbiter.sv
// Directed bench for datamem_arbiter with a behavioural async-read, write-through memory.
module tb_datamem_arbiter;

    logic        clk;
    logic        reset;
    logic        a_req, a_we, a_gnt, a_valid, a_err;
    logic [31:0] a_addr, a_data, a_q;
    logic        b_req, b_we, b_gnt, b_valid, b_err;
    logic [31:0] b_addr, b_data, b_q;
    logic [31:0] mem_addr, mem_data, mem_q;
    logic        mem_we;
    logic [1:0]  owner;

    logic [31:0] tb_mem [0:127];
    int compared;
    int mismatched;
    int vcount;
    logic exp_a;

    datamem_arbiter #(.ADDR_BITS(7), .MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_data(a_data),
        .a_gnt(a_gnt), .a_valid(a_valid), .a_q(a_q), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_data(b_data),
        .b_gnt(b_gnt), .b_valid(b_valid), .b_q(b_q), .b_err(b_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_data(mem_data), .mem_q(mem_q),
        .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb mem_q = mem_we ? mem_data : tb_mem[mem_addr[6:0]];
    always @(posedge clk) if (mem_we) tb_mem[mem_addr[6:0]] <= mem_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        for (int i = 0; i < 128; i++) tb_mem[i] = 32'h0;
        tb_mem[0] = 32'hCAFE0000;
        tb_mem[5] = 32'h00001234;
        for (int i = 0; i < 8; i++) tb_mem[16 + i] = 32'hB0000000 + i;
        reset = 1'b1;
        a_req = 0; a_we = 0; a_addr = 0; a_data = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_data = 0;
        tick(); tick();

        check("rst_a_valid", {31'b0, a_valid}, 32'h0);
        check("rst_a_q", a_q, 32'h0);
        check("rst_owner", {30'b0, owner}, 32'h0);
        a_req = 1; a_we = 1; a_addr = 7; a_data = 32'h77;
        #1;
        check("rst_a_gnt", {31'b0, a_gnt}, 32'h0);
        check("rst_mem_we", {31'b0, mem_we}, 32'h0);
        a_req = 0; a_we = 0;
        reset = 1'b0;
        tick();

        // A read of mem[5]
        a_req = 1; a_we = 0; a_addr = 5;
        #1;
        check("rd_a_gnt", {31'b0, a_gnt}, 32'h1);
        check("rd_b_gnt", {31'b0, b_gnt}, 32'h0);
        check("rd_mem_addr", mem_addr, 32'h5);
        tick();
        a_req = 0;
        check("rd_a_valid", {31'b0, a_valid}, 32'h1);
        check("rd_a_q", a_q, 32'h1234);
        check("rd_a_err", {31'b0, a_err}, 32'h0);
        check("rd_owner", {30'b0, owner}, 32'h1);
        tick();
        check("rd_a_valid_drop", {31'b0, a_valid}, 32'h0);
        check("rd_a_q_hold", a_q, 32'h1234);
        check("idle_owner", {30'b0, owner}, 32'h0);

        // A write then B read of the same word
        a_req = 1; a_we = 1; a_addr = 3; a_data = 32'hDEADBEEF;
        #1;
        check("wr_mem_we", {31'b0, mem_we}, 32'h1);
        tick();
        a_req = 0; a_we = 0;
        check("wr_a_valid", {31'b0, a_valid}, 32'h1);
        check("wr_a_q", a_q, 32'hDEADBEEF);
        b_req = 1; b_we = 0; b_addr = 3;
        #1;
        check("brd_b_gnt", {31'b0, b_gnt}, 32'h1);
        tick();
        b_req = 0;
        check("brd_b_valid", {31'b0, b_valid}, 32'h1);
        check("brd_b_q", b_q, 32'hDEADBEEF);
        check("brd_owner", {30'b0, owner}, 32'h2);

        // Both requesting continuously: AAAAB repeating
        a_req = 1; a_addr = 5; b_req = 1; b_addr = 3;
        for (int i = 0; i < 10; i++) begin
            exp_a = (i % 5) != 4;
            #1;
            check($sformatf("stream_a_gnt%0d", i), {31'b0, a_gnt}, {31'b0, exp_a});
            check($sformatf("stream_b_gnt%0d", i), {31'b0, b_gnt}, {31'b0, !exp_a});
            tick();
            check($sformatf("stream_b_valid%0d", i), {31'b0, b_valid}, {31'b0, !exp_a});
        end
        check("stream_b_q", b_q, 32'hDEADBEEF);

        // Dropping b_req clears the wait count
        tick(); tick();
        b_req = 0;
        tick();
        b_req = 1;
        for (int i = 0; i < 5; i++) begin
            exp_a = (i != 4);
            #1;
            check($sformatf("clr_a_gnt%0d", i), {31'b0, a_gnt}, {31'b0, exp_a});
            tick();
        end
        a_req = 0;

        // B-only stream of 8 reads
        vcount = 0;
        for (int i = 0; i < 8; i++) begin
            b_addr = 16 + i;
            #1;
            check($sformatf("bonly_gnt%0d", i), {31'b0, b_gnt}, 32'h1);
            tick();
            if (b_valid) vcount++;
            check($sformatf("bonly_q%0d", i), b_q, 32'hB0000000 + i);
        end
        b_req = 0;
        tick();
        if (b_valid) vcount++;
        check("bonly_pulses", vcount, 32'd8);

        // Out-of-range write
        a_req = 1; a_we = 1; a_addr = 32'h80; a_data = 32'h55;
        #1;
        check("oor_a_gnt", {31'b0, a_gnt}, 32'h1);
        check("oor_mem_we", {31'b0, mem_we}, 32'h0);
        tick();
        a_req = 0; a_we = 0;
        check("oor_a_valid", {31'b0, a_valid}, 32'h1);
        check("oor_a_err", {31'b0, a_err}, 32'h1);
        check("oor_a_q", a_q, 32'h0);
        check("oor_mem0", tb_mem[0], 32'hCAFE0000);
        tick();
        check("oor_a_err_hold", {31'b0, a_err}, 32'h1);

        // Reset mid-stream while a_gnt is high
        a_req = 1; a_addr = 5; b_req = 1; b_addr = 3;
        tick(); tick();
        check("prerst_a_valid", {31'b0, a_valid}, 32'h1);
        check("prerst_a_gnt", {31'b0, a_gnt}, 32'h1);
        reset = 1'b1;
        #1;
        check("midrst_a_valid", {31'b0, a_valid}, 32'h0);
        check("midrst_a_q", a_q, 32'h0);
        check("midrst_owner", {30'b0, owner}, 32'h0);
        check("midrst_a_gnt", {31'b0, a_gnt}, 32'h0);
        tick();
        check("midrst_no_resp", {31'b0, a_valid}, 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_a = (i != 4);
            #1;
            check($sformatf("postrst_a_gnt%0d", i), {31'b0, a_gnt}, {31'b0, exp_a});
            tick();
        end
        a_req = 0; b_req = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
